// File: rtl/aes_wb_stream_master.sv
// aes_wb_stream_master
//   Feeds a Wishbone-attached AES core from a valid/ready block stream and returns
//   each result on a second valid/ready stream. The module is a classic Wishbone
//   master. It runs the core's register sequence for a key load
//   (CONFIG, KEY0..7, CTRL.init, STATUS poll) and for a block
//   (BLOCK0..3, CTRL.next, STATUS poll, RESULT0..3).
//
//   Optional build macro AES_WB_TIMEOUT_EN: bounds each STATUS poll phase to
//   POLL_LIMIT reads. When the bound expires the master raises timeout_o, drops
//   key_ready_o, discards the block in flight and returns to idle. Without the
//   macro the master polls forever and timeout_o is tied low.
//
// Ports
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   key_i/keylen_i/encdec_i/key_load_i
//                         key material and its load strobe; key_i is sampled when
//                         the CONFIG write phase begins
//   s_valid_i/s_ready_o/s_data_i
//                         input block stream
//   m_valid_o/m_ready_i/m_data_o
//                         result stream; m_data_o stays stable while m_valid_o is held
//   wbm_*                 Wishbone master (single classic transfers)
//   key_ready_o           the key is expanded and blocks may be accepted
//   busy_o                a key load or block is in progress
//   timeout_o             sticky poll-timeout flag
module aes_wb_stream_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [255:0] key_i,
  input  logic         keylen_i,
  input  logic         encdec_i,
  input  logic         key_load_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [127:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [127:0] m_data_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  output logic         key_ready_o,
  output logic         busy_o,
  output logic         timeout_o
);

  // Register word offsets of the AES slave
  localparam logic [7:0] W_CTRL   = 8'h08;
  localparam logic [7:0] W_STATUS = 8'h09;
  localparam logic [7:0] W_CONFIG = 8'h0A;
  localparam logic [7:0] W_KEY0   = 8'h10;
  localparam logic [7:0] W_BLOCK0 = 8'h20;
  localparam logic [7:0] W_RES0   = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CFG, ST_KEY, ST_INIT, ST_KPOLL,
    ST_BLK, ST_NEXT, ST_BPOLL, ST_RES, ST_OUT
  } state_t;

  state_t       state_reg, state_next;
  logic         cyc_reg;        // a transfer is outstanding
  logic         gap_reg;        // the mandatory idle cycle after each ack
  logic [2:0]   idx_reg;        // word index within KEY/BLK/RES
  logic [255:0] key_reg;
  logic         keylen_reg, encdec_reg;
  logic [127:0] blk_reg;
  logic [31:0]  res_w_reg [4];
  logic         key_ready_reg;
  logic         pend_reg;       // key load requested while busy

  logic [31:0]  key_w [8];
  logic [31:0]  blk_w [4];

  logic         ack_s, rdy_s, poll_state, poll_expire;
  logic         start_load, accept, start_xfer, acc_state;
  logic [7:0]   adr_word_c;
  logic [31:0]  wdata_c;
  logic         we_c;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key_w
      assign key_w[gi] = key_reg[255-32*gi -: 32];
    end
    for (gi = 0; gi < 4; gi++) begin : g_blk_w
      assign blk_w[gi] = blk_reg[127-32*gi -: 32];
      assign m_data_o[127-32*gi -: 32] = res_w_reg[gi];
    end
  endgenerate

  assign ack_s      = cyc_reg & wbm_ack_i;
  assign rdy_s      = wbm_dat_i[0];
  assign poll_state = (state_reg == ST_KPOLL) || (state_reg == ST_BPOLL);
  assign acc_state  = (state_reg != ST_IDLE) && (state_reg != ST_OUT);
  assign start_xfer = acc_state && !cyc_reg && !gap_reg;

  // A key load (new or pending) takes priority over a waiting block.
  assign start_load = (state_reg == ST_IDLE) && (key_load_i || pend_reg);
  assign accept     = (state_reg == ST_IDLE) && !key_load_i && !pend_reg &&
                      key_ready_reg && s_valid_i;

`ifdef AES_WB_TIMEOUT_EN
  localparam int PCW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  logic [PCW-1:0] poll_cnt_reg;
  logic           timeout_reg;

  // Expire on the ack of the POLL_LIMIT-th consecutive not-ready STATUS read
  assign poll_expire = poll_state && ack_s && !rdy_s &&
                       (poll_cnt_reg == PCW'(POLL_LIMIT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      poll_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (!poll_state)
        poll_cnt_reg <= '0;
      else if (ack_s && !rdy_s)
        poll_cnt_reg <= poll_cnt_reg + 1'b1;
      if (start_load)
        timeout_reg <= 1'b0;
      else if (poll_expire)
        timeout_reg <= 1'b1;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign poll_expire = 1'b0;
  assign timeout_o   = 1'b0;
  // POLL_LIMIT only has an effect in the timeout build
  if (POLL_LIMIT == 0) begin : g_poll_limit_unused
  end
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start_load) state_next = ST_CFG;
                else if (accept) state_next = ST_BLK;
      ST_CFG:   if (ack_s) state_next = ST_KEY;
      ST_KEY:   if (ack_s && idx_reg == 3'd7) state_next = ST_INIT;
      ST_INIT:  if (ack_s) state_next = ST_KPOLL;
      ST_KPOLL: if (ack_s && rdy_s) state_next = ST_IDLE;
                else if (poll_expire) state_next = ST_IDLE;
      ST_BLK:   if (ack_s && idx_reg == 3'd3) state_next = ST_NEXT;
      ST_NEXT:  if (ack_s) state_next = ST_BPOLL;
      ST_BPOLL: if (ack_s && rdy_s) state_next = ST_RES;
                else if (poll_expire) state_next = ST_IDLE;
      ST_RES:   if (ack_s && idx_reg == 3'd3) state_next = ST_OUT;
      ST_OUT:   if (m_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Bus sequencing and datapath
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_reg       <= 1'b0;
      gap_reg       <= 1'b0;
      idx_reg       <= 3'd0;
      key_reg       <= '0;
      keylen_reg    <= 1'b0;
      encdec_reg    <= 1'b0;
      blk_reg       <= '0;
      key_ready_reg <= 1'b0;
      pend_reg      <= 1'b0;
      for (int i = 0; i < 4; i++)
        res_w_reg[i] <= '0;
    end else begin
      // One transfer at a time; cyc drops for exactly one cycle after each ack
      if (ack_s) begin
        cyc_reg <= 1'b0;
        gap_reg <= 1'b1;
      end else if (start_xfer) begin
        cyc_reg <= 1'b1;
      end else begin
        gap_reg <= 1'b0;
      end

      if (state_next != state_reg)
        idx_reg <= 3'd0;
      else if (ack_s && (state_reg == ST_KEY || state_reg == ST_BLK || state_reg == ST_RES))
        idx_reg <= idx_reg + 3'd1;

      // A pending request is consumed on the IDLE cycle that starts the load
      if (state_reg == ST_IDLE)
        pend_reg <= 1'b0;
      else if (key_load_i)
        pend_reg <= 1'b1;

      if (start_load) begin
        key_reg       <= key_i;
        keylen_reg    <= keylen_i;
        encdec_reg    <= encdec_i;
        key_ready_reg <= 1'b0;
      end else if (state_reg == ST_KPOLL && ack_s && rdy_s) begin
        key_ready_reg <= 1'b1;
      end else if (poll_expire) begin
        key_ready_reg <= 1'b0;
      end

      if (accept)
        blk_reg <= s_data_i;

      if (state_reg == ST_RES && ack_s)
        res_w_reg[idx_reg[1:0]] <= wbm_dat_i;
    end
  end

  // Output logic: bus address/data follow the state and word index
  always_comb begin
    adr_word_c = 8'h00;
    wdata_c    = 32'd0;
    we_c       = 1'b0;
    unique case (state_reg)
      ST_CFG:   begin adr_word_c = W_CONFIG; wdata_c = {30'd0, keylen_reg, encdec_reg}; we_c = 1'b1; end
      ST_KEY:   begin adr_word_c = W_KEY0 + {5'd0, idx_reg}; wdata_c = key_w[idx_reg]; we_c = 1'b1; end
      ST_INIT:  begin adr_word_c = W_CTRL; wdata_c = 32'd1; we_c = 1'b1; end
      ST_KPOLL: adr_word_c = W_STATUS;
      ST_BLK:   begin adr_word_c = W_BLOCK0 + {5'd0, idx_reg}; wdata_c = blk_w[idx_reg[1:0]]; we_c = 1'b1; end
      ST_NEXT:  begin adr_word_c = W_CTRL; wdata_c = 32'd2; we_c = 1'b1; end
      ST_BPOLL: adr_word_c = W_STATUS;
      ST_RES:   adr_word_c = W_RES0 + {5'd0, idx_reg};
      default:  adr_word_c = 8'h00;
    endcase
  end

  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = cyc_reg;
  assign wbm_we_o    = cyc_reg & we_c;
  assign wbm_sel_o   = 4'hF;
  assign wbm_adr_o   = cyc_reg ? (BASE_ADDR + {22'd0, adr_word_c, 2'b00}) : 32'd0;
  assign wbm_dat_o   = cyc_reg ? wdata_c : 32'd0;
  assign s_ready_o   = accept;
  assign m_valid_o   = (state_reg == ST_OUT);
  assign busy_o      = (state_reg != ST_IDLE);
  assign key_ready_o = key_ready_reg;

endmodule

// File: tb/tb_aes_wb_stream_master.sv
// Directed bench for aes_wb_stream_master. A behavioural Wishbone slave answers
// with a registered ack, logs every transfer and emulates the AES core with a
// table of known vectors.
module tb_aes_wb_stream_master;
  localparam logic [31:0]  BASE    = 32'h3000_0000;
  localparam logic [255:0] K128    = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
  localparam logic [127:0] K128_HI = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic [255:0] key_i = '0;
  logic         keylen_i = 1'b0, encdec_i = 1'b0, key_load_i = 1'b0;
  logic         s_valid_i = 1'b0, s_ready_o;
  logic [127:0] s_data_i = '0;
  logic         m_valid_o, m_ready_i = 1'b0;
  logic [127:0] m_data_o;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic [31:0]  wbm_dat_i = '0;
  logic         wbm_ack_i = 1'b0;
  logic         key_ready_o, busy_o, timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  aes_wb_stream_master #(.BASE_ADDR(BASE), .POLL_LIMIT(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .key_i(key_i), .keylen_i(keylen_i), .encdec_i(encdec_i), .key_load_i(key_load_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .key_ready_o(key_ready_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // ---------------- slave model ----------------
  logic [31:0]  kreg [8];
  logic [31:0]  breg [4];
  logic [31:0]  rreg [4];
  logic [1:0]   cfg = 2'b00;
  int           status_left = 0;
  int           status_reads = 0;
  bit           stuck = 1'b0;
  logic [32:0]  log_q [$];
  logic [31:0]  off;
  logic [7:0]   w;
  logic [127:0] res;

  function automatic logic [127:0] core_model(input logic [255:0] k, input logic kl,
                                              input logic ed, input logic [127:0] b);
    if (!kl && ed && k[255:128] == K128_HI && b == PT) return CT128;
    if (kl && ed && k == K256 && b == PT) return CT256;
    if (kl && !ed && k == K256 && b == CT256) return PT;
    return ~b;
  endfunction

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_ack_i <= 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
      wbm_ack_i <= 1'b1;
      off = wbm_adr_o - BASE;
      w   = off[9:2];
      log_q.push_back({wbm_we_o, wbm_adr_o});
      if (wbm_we_o) begin
        wbm_dat_i <= 32'd0;
        if (w >= 8'h10 && w <= 8'h17) kreg[w[2:0]] = wbm_dat_o;
        else if (w >= 8'h20 && w <= 8'h23) breg[w[1:0]] = wbm_dat_o;
        else if (w == 8'h0A) cfg = wbm_dat_o[1:0];
        else if (w == 8'h08) begin
          status_reads = 0;
          status_left  = 2;
          if (wbm_dat_o == 32'd2) begin
            res = core_model({kreg[0], kreg[1], kreg[2], kreg[3], kreg[4], kreg[5], kreg[6], kreg[7]},
                             cfg[1], cfg[0], {breg[0], breg[1], breg[2], breg[3]});
            rreg[0] = res[127:96]; rreg[1] = res[95:64]; rreg[2] = res[63:32]; rreg[3] = res[31:0];
          end
        end
      end else begin
        if (w == 8'h09) begin
          status_reads++;
          if (stuck) wbm_dat_i <= 32'd0;
          else if (status_left == 0) wbm_dat_i <= 32'd1;
          else begin status_left--; wbm_dat_i <= 32'd0; end
        end else if (w >= 8'h30 && w <= 8'h33) wbm_dat_i <= rreg[w[1:0]];
        else wbm_dat_i <= 32'd0;
      end
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_key(input logic [255:0] k, input logic kl, input logic ed);
    key_i = k; keylen_i = kl; encdec_i = ed; key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
  endtask

  task automatic wait_key_ready(input string tag);
    int n = 0;
    while (!(key_ready_o && !busy_o) && n < 400) begin tick; n++; end
    check(tag, {255'd0, key_ready_o}, 256'd1);
  endtask

  task automatic send_block(input logic [127:0] d, input string tag);
    int n = 0;
    s_valid_i = 1'b1; s_data_i = d;
    #1;
    while (!s_ready_o && n < 400) begin tick; n++; end
    check(tag, {255'd0, s_ready_o}, 256'd1);
    tick;
    s_valid_i = 1'b0;
  endtask

  task automatic take_result(input logic [127:0] exp, input string tag);
    int n = 0;
    while (!m_valid_o && n < 400) begin tick; n++; end
    check({tag, "_valid"}, {255'd0, m_valid_o}, 256'd1);
    check({tag, "_data"}, {128'd0, m_data_o}, {128'd0, exp});
    m_ready_i = 1'b1;
    tick;
    m_ready_i = 1'b0;
    check({tag, "_drop"}, {255'd0, m_valid_o}, 256'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int mark, n, kc;
    bit ok, seen_blk, stable;
    logic [31:0] a;

    // Reset values
    wb_rst_i = 1'b1;
    repeat (3) tick;
    check("rst_cyc", {255'd0, wbm_cyc_o}, 256'd0);
    check("rst_stb", {255'd0, wbm_stb_o}, 256'd0);
    check("rst_we", {255'd0, wbm_we_o}, 256'd0);
    check("rst_sel", {252'd0, wbm_sel_o}, 256'hF);
    check("rst_adr_dat", {192'd0, wbm_adr_o, wbm_dat_o}, 256'd0);
    check("rst_stream", {253'd0, s_ready_o, m_valid_o, key_ready_o}, 256'd0);
    check("rst_mdata", {128'd0, m_data_o}, 256'd0);
    check("rst_busy_to", {254'd0, busy_o, timeout_o}, 256'd0);
    wb_rst_i = 1'b0;
    tick;

    // AES-128 encrypt key load and bus sequence
    mark = log_q.size();
    pulse_key(K128, 1'b0, 1'b1);
    check("load_busy", {255'd0, busy_o}, 256'd1);
    wait_key_ready("k128_ready");
    check("k128_log_len", 256'(log_q.size() - mark), 256'd13);
    check("k128_cfg_wr", {223'd0, log_q[mark]}, {223'd0, 1'b1, BASE + 32'h28});
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = BASE + 32'h40 + 32'(4 * i);
      if (log_q[mark + 1 + i] !== {1'b1, a}) ok = 1'b0;
    end
    check("k128_key_order", {255'd0, ok}, 256'd1);
    check("k128_init_wr", {223'd0, log_q[mark + 9]}, {223'd0, 1'b1, BASE + 32'h20});
    check("k128_status_rd", {223'd0, log_q[mark + 10]}, {223'd0, 1'b0, BASE + 32'h24});
    check("k128_status_cnt", 256'(status_reads), 256'd3);
    check("k128_cfg_val", {254'd0, cfg}, 256'd1);
    check("k128_key_words", {192'd0, kreg[0], kreg[4]}, {192'd0, 32'h00010203, 32'h0});

    // Block through AES-128, then hold the result 20 cycles
    send_block(PT, "b1_accept");
    n = 0;
    while (!m_valid_o && n < 400) begin tick; n++; end
    check("b1_data", {128'd0, m_data_o}, {128'd0, CT128});
    s_valid_i = 1'b1; s_data_i = CT128;
    stable = 1'b1;
    repeat (20) begin
      tick;
      if (!m_valid_o || m_data_o !== CT128 || s_ready_o) stable = 1'b0;
    end
    check("hold_stable", {255'd0, stable}, 256'd1);
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    tick;
    m_ready_i = 1'b0;
    check("hold_drop", {255'd0, m_valid_o}, 256'd0);

    // AES-256 encrypt then decrypt
    pulse_key(K256, 1'b1, 1'b1);
    wait_key_ready("k256e_ready");
    send_block(PT, "b2_accept");
    take_result(CT256, "b2");
    pulse_key(K256, 1'b1, 1'b0);
    wait_key_ready("k256d_ready");
    send_block(CT256, "b3_accept");
    take_result(PT, "b3");

    // Key load during BPOLL: old block finishes first, then the new key loads
    send_block(CT256, "b4_accept");
    n = 0;
    while (!(wbm_cyc_o && !wbm_we_o && wbm_adr_o == BASE + 32'h24) && n < 200) begin tick; n++; end
    check("b4_in_bpoll", {255'd0, wbm_cyc_o}, 256'd1);
    pulse_key(K128, 1'b0, 1'b1);
    take_result(PT, "b4_old_key");
    mark = log_q.size();
    send_block(PT, "b5_accept");
    take_result(CT128, "b5_new_key");
    check("b5_cfg_first", {223'd0, log_q[mark]}, {223'd0, 1'b1, BASE + 32'h28});
    kc = 0; seen_blk = 1'b0;
    for (int i = mark; i < log_q.size(); i++) begin
      if (!seen_blk) begin
        if (log_q[i] == {1'b1, BASE + 32'h80}) seen_blk = 1'b1;
        else if (log_q[i][32] && log_q[i][31:0] >= BASE + 32'h40 && log_q[i][31:0] <= BASE + 32'h5C) kc++;
      end
    end
    check("b5_keys_before_blk", 256'(kc), 256'd8);
    check("b5_blk_seen", {255'd0, seen_blk}, 256'd1);

    // key_load_i and s_valid_i in the same IDLE cycle: key load wins
    mark = log_q.size();
    key_i = K256; keylen_i = 1'b1; encdec_i = 1'b1;
    key_load_i = 1'b1; s_valid_i = 1'b1; s_data_i = PT;
    #1;
    check("tie_no_accept", {255'd0, s_ready_o}, 256'd0);
    tick;
    key_load_i = 1'b0;
    check("tie_busy_kr", {254'd0, busy_o, key_ready_o}, 256'd2);
    send_block(PT, "b6_accept");
    take_result(CT256, "b6");
    check("b6_cfg_first", {223'd0, log_q[mark]}, {223'd0, 1'b1, BASE + 32'h28});

    // Reset during the KEY3 write
    key_i = K128; keylen_i = 1'b0; encdec_i = 1'b1; key_load_i = 1'b1;
    tick;
    key_load_i = 1'b0;
    n = 0;
    while (!(wbm_cyc_o && wbm_adr_o == BASE + 32'h4C) && n < 200) begin tick; n++; end
    check("rst_key3_seen", {255'd0, wbm_cyc_o}, 256'd1);
    wb_rst_i = 1'b1;
    tick;
    check("rst_mid_cyc_stb", {254'd0, wbm_cyc_o, wbm_stb_o}, 256'd0);
    check("rst_mid_adr_dat", {192'd0, wbm_adr_o, wbm_dat_o}, 256'd0);
    check("rst_mid_flags", {251'd0, busy_o, key_ready_o, m_valid_o, s_ready_o, timeout_o}, 256'd0);
    wb_rst_i = 1'b0;
    tick;

`ifdef AES_WB_TIMEOUT_EN
    // Stuck STATUS: 16 reads, then timeout
    stuck = 1'b1;
    pulse_key(K128, 1'b0, 1'b1);
    n = 0;
    while (busy_o && n < 800) begin tick; n++; end
    check("to_idle", {255'd0, busy_o}, 256'd0);
    check("to_flag", {255'd0, timeout_o}, 256'd1);
    check("to_key_ready", {255'd0, key_ready_o}, 256'd0);
    check("to_reads", 256'(status_reads), 256'd16);
    stuck = 1'b0;
`else
    check("no_timeout", {255'd0, timeout_o}, 256'd0);
`endif

    // Recovery after reset (and timeout)
    pulse_key(K128, 1'b0, 1'b1);
    wait_key_ready("rec_ready");
    check("rec_timeout_clr", {255'd0, timeout_o}, 256'd0);
    send_block(PT, "rec_accept");
    take_result(CT128, "rec");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
